// File: rtl/dmem_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_dump_reader
//  Description : Streams a contiguous window of the 2K x 32 data memory out
//                on a valid/ready interface. The block reads one word at a
//                time over an arbitrated single-port bus and never writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_dump_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic              mem_oen,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    localparam int                LAST_I    = DEPTH - 1;
    localparam logic [ADDR_W:0]   DEPTH_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR = LAST_I[ADDR_W-1:0];

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   count_clamped;
    logic [ADDR_W-1:0] next_addr;

    // Requests longer than the memory read every word exactly once
    always_comb begin
        count_clamped = (count > DEPTH_CNT) ? DEPTH_CNT : count;
    end

    // Address increment wraps at the top of the memory
    always_comb begin
        next_addr = (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
    end

    // Read-only port: the write strobe is held inactive, output always driven
    assign mem_wen  = 1'b1;
    assign mem_oen  = 1'b0;
    assign mem_addr = cur_addr;
    assign bus_req  = busy;
    // A read is launched only in a granted ISSUE cycle
    assign mem_cen  = (state == ISSUE) ? ~bus_gnt : 1'b1;

    // Main sequencer: issue, capture, then hold the word until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                // Cancel wins over any same-cycle handshake; no done pulse
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (count_clamped == '0) begin
                                done <= 1'b1;
                            end else begin
                                cur_addr  <= base_addr;
                                remaining <= count_clamped;
                                busy      <= 1'b1;
                                state     <= ISSUE;
                            end
                        end
                    end
                    ISSUE: begin
                        if (bus_gnt) begin
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        out_data  <= mem_q;
                        out_addr  <= cur_addr;
                        out_last  <= (remaining == 1);
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                    SEND: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (out_last) begin
                                out_last <= 1'b0;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                cur_addr  <= next_addr;
                                remaining <= remaining - 1'b1;
                                state     <= ISSUE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_dump_reader
//  Description : Directed self-checking bench for dmem_dump_reader with a
//                synchronous-read memory model and a stream monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_dump_reader;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2048;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              abort;
    logic              busy;
    logic              done;
    logic              bus_req;
    logic              bus_gnt;
    logic              mem_cen;
    logic              mem_wen;
    logic              mem_oen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    int checks   = 0;
    int failures = 0;

    dmem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .count(count), .abort(abort), .busy(busy), .done(done),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_cen(mem_cen),
        .mem_wen(mem_wen), .mem_oen(mem_oen), .mem_addr(mem_addr),
        .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM model
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) if (!mem_cen) mem_q <= mem[mem_addr];

    // Stream monitor, sampled mid-cycle
    logic [ADDR_W-1:0] b_addr [$];
    logic [DATA_W-1:0] b_data [$];
    logic              b_last [$];
    int                b_cyc  [$];
    int ncen = 0, ndone = 0, done_cyc = 0, nbusy = 0, port_bad = 0;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !abort) begin
            b_addr.push_back(out_addr);
            b_data.push_back(out_data);
            b_last.push_back(out_last);
            b_cyc.push_back(cyc);
        end
        if (!mem_cen) ncen++;
        if (done) begin ndone++; done_cyc = cyc; end
        if (busy) nbusy++;
        if (mem_wen !== 1'b1 || mem_oen !== 1'b0) port_bad++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic clear_mon();
        b_addr.delete(); b_data.delete(); b_last.delete(); b_cyc.delete();
        ncen = 0; ndone = 0; done_cyc = 0; nbusy = 0;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n, output int c0);
        step();
        start = 1'b1; base_addr = b; count = n; c0 = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && ndone == 0; i++) step();
        checks++;
        if (ndone == 0) begin
            failures++;
            $display("FAIL done_timeout got=no_done exp=done within %0d cycles", budget);
        end
        step(); step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, done, bus_req, out_valid, out_last, mem_cen} !== 6'b000001) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000001", {busy, done, bus_req, out_valid, out_last, mem_cen});
        end
        checks++;
        if (out_data !== '0 || out_addr !== '0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", out_data, out_addr, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int c0;
        mem[16] = 32'hA000_00A0; mem[17] = 32'hA111_00A1;
        mem[18] = 32'hA222_00A2; mem[19] = 32'hA333_00A3;
        bus_gnt = 1'b1; out_ready = 1'b1;
        clear_mon();
        do_start(11'h010, 12'd4, c0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus_req !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%b%b exp=11", busy, bus_req);
        end
        wait_done(40);
        checks++;
        if (b_addr.size() != 4) begin
            failures++;
            $display("FAIL basic_beats got=%0d exp=4", b_addr.size());
        end
        for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
            checks++;
            if (b_addr[i] !== 11'(16 + i) || b_data[i] !== mem[16 + i] ||
                b_last[i] !== (i == 3) || b_cyc[i] != c0 + 3 + 3 * i) begin
                failures++;
                $display("FAIL basic_beat%0d got=%h/%h/%b@%0d exp=%h/%h/%b@%0d", i, b_addr[i], b_data[i],
                         b_last[i], b_cyc[i] - c0, 11'(16 + i), mem[16 + i], (i == 3), 3 + 3 * i);
            end
        end
        checks++;
        if (ndone != 1 || done_cyc != c0 + 13 || ncen != 4) begin
            failures++;
            $display("FAIL basic_done got=%0d@%0d cen=%0d exp=1@13 cen=4", ndone, done_cyc - c0, ncen);
        end
    endtask

    task automatic test_wrap();
        int c0;
        logic [ADDR_W-1:0] ea [4];
        ea[0] = 11'h7FE; ea[1] = 11'h7FF; ea[2] = 11'h000; ea[3] = 11'h001;
        for (int i = 0; i < 4; i++) mem[ea[i]] = 32'hBEEF_0000 | 32'(ea[i]);
        clear_mon();
        do_start(11'h7FE, 12'd4, c0);
        wait_done(40);
        checks++;
        if (b_addr.size() != 4) begin
            failures++;
            $display("FAIL wrap_beats got=%0d exp=4", b_addr.size());
        end
        for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
            checks++;
            if (b_addr[i] !== ea[i] || b_data[i] !== mem[ea[i]]) begin
                failures++;
                $display("FAIL wrap_beat%0d got=%h/%h exp=%h/%h", i, b_addr[i], b_data[i], ea[i], mem[ea[i]]);
            end
        end
    endtask

    task automatic test_backpressure();
        int c0, n_before;
        int exp_c [4];
        for (int i = 0; i < 4; i++) mem[32 + i] = 32'h2200_0000 + 32'(i * 7);
        clear_mon();
        do_start(11'h020, 12'd4, c0);
        go_to(c0 + 4);
        out_ready = 1'b0;
        go_to(c0 + 6);
        n_before = ncen;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 11'h021 || out_data !== mem[33]) begin
                failures++;
                $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/021/%h", i, out_valid, out_addr, out_data, mem[33]);
            end
            step();
        end
        checks++;
        if (ncen != n_before || n_before != 2) begin
            failures++;
            $display("FAIL bp_no_read got=%0d exp=2", ncen);
        end
        out_ready = 1'b1;
        wait_done(40);
        exp_c[0] = 3; exp_c[1] = 11; exp_c[2] = 14; exp_c[3] = 17;
        checks++;
        if (b_addr.size() != 4) begin
            failures++;
            $display("FAIL bp_beats got=%0d exp=4", b_addr.size());
        end
        for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
            checks++;
            if (b_addr[i] !== 11'(32 + i) || b_data[i] !== mem[32 + i] || b_cyc[i] != c0 + exp_c[i]) begin
                failures++;
                $display("FAIL bp_beat%0d got=%h/%h@%0d exp=%h/%h@%0d", i, b_addr[i], b_data[i],
                         b_cyc[i] - c0, 11'(32 + i), mem[32 + i], exp_c[i]);
            end
        end
    endtask

    task automatic test_grant();
        int c0;
        mem[48] = 32'h3030_ABCD;
        clear_mon();
        bus_gnt = 1'b0;
        do_start(11'h030, 12'd1, c0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (mem_cen !== 1'b1 || bus_req !== 1'b1) begin
                failures++;
                $display("FAIL gnt_wait%0d got=cen%b req%b exp=cen1 req1", i, mem_cen, bus_req);
            end
            step();
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_cen !== 1'b0 || mem_addr !== 11'h030) begin
            failures++;
            $display("FAIL gnt_issue got=cen%b addr%h exp=cen0 addr030", mem_cen, mem_addr);
        end
        wait_done(20);
        checks++;
        if (b_addr.size() != 1 || b_data[0] !== 32'h3030_ABCD || b_last[0] !== 1'b1 ||
            b_cyc[0] != c0 + 9 || ncen != 1) begin
            failures++;
            $display("FAIL gnt_beat got=n%0d d%h@%0d cen%0d exp=n1 d3030abcd@9 cen1",
                     b_addr.size(), b_data[0], b_cyc[0] - c0, ncen);
        end
    endtask

    task automatic test_zero_and_clamp();
        int c0, errs, lasts;
        logic [ADDR_W-1:0] a;
        clear_mon();
        do_start(11'h005, 12'd0, c0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done got=done%b busy%b exp=done1 busy0", done, busy);
        end
        step(); step(); step();
        checks++;
        if (ndone != 1 || nbusy != 0 || ncen != 0 || b_addr.size() != 0) begin
            failures++;
            $display("FAIL zero_quiet got=d%0d b%0d c%0d n%0d exp=d1 b0 c0 n0", ndone, nbusy, ncen, b_addr.size());
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0003);
        clear_mon();
        do_start(11'h100, 12'd3000, c0);
        wait_done(7000);
        checks++;
        if (b_addr.size() != DEPTH || ncen != DEPTH) begin
            failures++;
            $display("FAIL clamp_beats got=%0d cen=%0d exp=%0d", b_addr.size(), ncen, DEPTH);
        end
        errs = 0; lasts = 0;
        for (int i = 0; i < b_addr.size(); i++) begin
            a = 11'((256 + i) % DEPTH);
            if (b_addr[i] !== a || b_data[i] !== mem[a]) errs++;
            if (b_last[i] === 1'b1) lasts++;
        end
        checks++;
        if (errs != 0 || lasts != 1 || b_last[DEPTH - 1] !== 1'b1) begin
            failures++;
            $display("FAIL clamp_content got=errs%0d lasts%0d exp=errs0 lasts1", errs, lasts);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        clear_mon();
        do_start(11'h010, 12'd2, c0);
        go_to(c0 + 2);
        start = 1'b1; base_addr = 11'h050; count = 12'd1;
        step();
        start = 1'b0;
        go_to(c0 + 7);
        start = 1'b1; base_addr = 11'h012; count = 12'd1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done_overlap got=%b exp=1", done);
        end
        step();
        start = 1'b0;
        go_to(c0 + 14);
        checks++;
        if (b_addr.size() != 3) begin
            failures++;
            $display("FAIL b2b_beats got=%0d exp=3", b_addr.size());
        end else begin
            checks++;
            if (b_addr[0] !== 11'h010 || b_addr[1] !== 11'h011 || b_addr[2] !== 11'h012 ||
                b_data[2] !== mem[18] || b_cyc[2] != c0 + 10) begin
                failures++;
                $display("FAIL b2b_seq got=%h,%h,%h@%0d exp=010,011,012@10", b_addr[0], b_addr[1], b_addr[2], b_cyc[2] - c0);
            end
        end
        checks++;
        if (ndone != 2 || done_cyc != c0 + 11) begin
            failures++;
            $display("FAIL b2b_done got=%0d@%0d exp=2@11", ndone, done_cyc - c0);
        end
    endtask

    task automatic test_abort();
        int c0;
        clear_mon();
        do_start(11'h040, 12'd4, c0);
        go_to(c0 + 4);
        out_ready = 1'b0;
        go_to(c0 + 6);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== 11'h041) begin
            failures++;
            $display("FAIL abort_pre got=%b/%h exp=1/041", out_valid, out_addr);
        end
        step();
        abort = 1'b1; out_ready = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || bus_req !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got=v%b b%b r%b exp=v0 b0 r0", out_valid, busy, bus_req);
        end
        repeat (10) step();
        checks++;
        if (ndone != 0 || b_addr.size() != 1 || ncen != 2) begin
            failures++;
            $display("FAIL abort_after got=d%0d n%0d c%0d exp=d0 n1 c2", ndone, b_addr.size(), ncen);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_mon();
        do_start(11'h060, 12'd4, c0);
        go_to(c0 + 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bus_req, out_valid, out_last, mem_cen} !== 6'b000001 ||
            out_data !== '0 || out_addr !== '0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL rstmid_outs got=%b/%h/%h/%h exp=000001/0/0/0",
                     {busy, done, bus_req, out_valid, out_last, mem_cen}, out_data, out_addr, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem[0] = 32'h0BAD_F00D;
        clear_mon();
        do_start(11'h000, 12'd1, c0);
        wait_done(20);
        checks++;
        if (b_addr.size() != 1 || b_addr[0] !== 11'h000 || b_data[0] !== 32'h0BAD_F00D ||
            b_last[0] !== 1'b1 || b_cyc[0] != c0 + 3 || done_cyc != c0 + 4) begin
            failures++;
            $display("FAIL rstmid_restart got=n%0d %h/%h@%0d done@%0d exp=n1 000/0badf00d@3 done@4",
                     b_addr.size(), b_addr[0], b_data[0], b_cyc[0] - c0, done_cyc - c0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; abort = 1'b0;
        bus_gnt = 1'b1; out_ready = 1'b1; mem_q = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + 32'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_grant();
        test_zero_and_clamp();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        checks++;
        if (port_bad != 0) begin
            failures++;
            $display("FAIL port_strobes got=%0d bad cycles exp=0", port_bad);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_dump_reader.md
Name: dmem_dump_reader

Overview:
- Read-side engine for the 2K x 32 data memory that the execute stage writes through its store path.
- On a start command it performs bus-arbitrated single-word reads of a contiguous address window and streams each word out on a valid/ready interface with its address and a last flag.
- Used for post-run memory dumps and testbench result checking. It sits beside the execute stage on the shared data-memory port; the arbiter grants the port to one master at a time.

Parameters:
- ADDR_W, 11, data-memory word-address width
- DATA_W, 32, data-memory word width
- DEPTH, 2048, number of words; addresses wrap modulo DEPTH

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; sampled with start
- count  in  ADDR_W+1  words to read; sampled with start; values above DEPTH clamp to DEPTH
- abort  in  1  synchronous cancel
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- done  out  1  1-cycle pulse when the last word handshakes, or on a zero-count start
- bus_req  out  1  port request to the arbiter; equals busy
- bus_gnt  in  1  port grant from the arbiter
- mem_cen  out  1  RAM chip enable, active low
- mem_wen  out  1  RAM write enable, active low; tied to 1 (read only)
- mem_oen  out  1  RAM output enable, active low; tied to 0
- mem_addr  out  ADDR_W  RAM address
- mem_q  in  DATA_W  RAM read data; valid the cycle after the edge that sampled mem_cen=0
- out_valid  out  1  stream data valid
- out_ready  in  1  downstream ready
- out_data  out  DATA_W  word read
- out_addr  out  ADDR_W  address of out_data
- out_last  out  1  high with the final word of a dump

Behaviour:
- Reset values (asynchronous, rst_n=0): state IDLE; busy, done, bus_req, out_valid, out_last = 0; out_data, out_addr, mem_addr = 0; mem_cen = 1.
- States:
  - IDLE
    - start with clamped count 0: done=1 next cycle, no reads, stay IDLE.
    - start with clamped count >= 1: latch cur_addr = base_addr and remaining = clamped count, then go to ISSUE.
  - ISSUE
    - mem_addr = cur_addr.
    - mem_cen = ~bus_gnt, combinational; a read is issued only in a granted cycle.
    - gnt=1 goes to CAPTURE; gnt=0 stays in ISSUE indefinitely.
  - CAPTURE
    - mem_cen = 1.
    - At the end of the cycle, register out_data = mem_q, out_addr = cur_addr, out_last = (remaining == 1), and out_valid = 1.
    - Always goes to SEND; the grant is not checked.
  - SEND
    - Hold out_valid and all out_* stable until out_valid & out_ready are both high at an edge.
    - On that handshake: out_valid = 0.
      - If out_last: done = 1 for one cycle, go to IDLE.
      - Otherwise: cur_addr = (cur_addr + 1) mod DEPTH, remaining--, go to ISSUE.
- Latency: granted ISSUE in cycle t gives out_valid high in cycle t+2. Peak throughput is 1 word per 3 cycles; only one read is outstanding.
- Wrap-around: address 0x7FF is followed by 0x000. count = 2048 reads every word exactly once.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle as a done pulse is accepted, since the FSM is already in IDLE.
- abort, sampled in any state other than IDLE:
  - Next cycle: IDLE, out_valid = 0, busy = 0, no done pulse.
  - Any in-flight read result is discarded.
  - abort has priority over a same-cycle handshake.
- Reset mid-operation: immediate IDLE with all outputs at reset values. The first post-reset start behaves as though from power-up.
- mem_wen is never 0, so this block cannot corrupt memory.

Test Plan:
- Preload words 0x010..0x013 = A0,A1,A2,A3; start base=0x010 count=4, gnt=1, ready=1 -> four beats (0x010,A0)..(0x013,A3), each 3 cycles apart; out_last only on 0x013; done pulses on the cycle after the 0x013 handshake.
- Wrap: base=0x7FE count=4 -> out_addr sequence 0x7FE, 0x7FF, 0x000, 0x001 with matching data.
- Backpressure: ready=0 for 5 cycles on beat 2 -> out_valid, data and addr held stable; no new mem_cen=0 pulse; stream resumes with beat 3 after ready rises.
- Grant withheld: gnt=0 for 6 cycles after start -> mem_cen stays 1 and bus_req stays 1; first read is issued on the first gnt=1 cycle.
- count=0 -> done pulses the cycle after start, busy never rises, no mem_cen pulse. count=3000 -> exactly 2048 beats.
- abort during SEND of beat 2 of 4 -> IDLE next cycle, no done pulse. rst_n low during CAPTURE -> outputs at reset values immediately; a following start base=0 count=1 completes normally.
